pe_array_sequencer: RTL
=======================

Name: pe_array_sequencer

Overview:
- Sequences configuration and execution of the 4-row PE array.
- Fetches PE instruction words from a valid/ready config source and issues one init strobe per slot, row-major.
- Then issues run strobes over the same slot order for a programmed number of iterations.
- Sits between the top-level control interface and the PE array's init/run/pe_config inputs.

Parameters:
- ROWS, 4, number of PE rows; row select is 2 bits.
- SLOTS, 4, slots per row (sel 0 = LSU, 1..SLOTS-1 = PEs); 1..7.
- CFG_W, `PE_inst, width of one configuration word.
- ITER_W, 16, width of the iteration count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  level; forces return to IDLE.
- iter_count  in  ITER_W  run sweeps; sampled on an accepted start.
- stall  in  1  freezes LOAD/RUN counters and strobes.
- cfg_valid  in  1  config word valid.
- cfg_data  in  CFG_W  config word.
- cfg_ready  out  1  config word accepted this cycle.
- init_PE_array  out  5  {row_sel[1:0], slot_sel[2:0]}.
- run_PE_array  out  5  {row_sel[1:0], slot_sel[2:0]}.
- pe_config  out  CFG_W  registered config word, aligned with the init strobe.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle pulse at RUN completion.

Behaviour:
- Reset state: IDLE, counters 0. Outputs: init_PE_array = run_PE_array = 5'b00111, pe_config = 0, cfg_ready = 0, busy = 0, done = 0.
- Idle code: slot_sel = 3'b111 means no slot is selected, because row decode is always one-hot.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: start moves to LOAD and latches iter_count. If the latched iter_count is 0, load still occurs, then RUN is skipped and the FSM goes LOAD -> DONE.
- LOAD:
  - cfg_ready = !stall.
  - On cfg_valid && cfg_ready, the next cycle drives init_PE_array = {row, slot} and pe_config = cfg_data. Latency from handshake to strobe is 1 cycle.
  - Then slot increments; at SLOTS-1, slot wraps to 0 and row increments.
  - After the word for {ROWS-1, SLOTS-1}, go to RUN. Exactly ROWS*SLOTS words are accepted.
  - If no handshake occurs, init_PE_array shows the idle code and pe_config holds its last value.
- RUN:
  - Each non-stalled cycle drives run_PE_array = {row, slot} with the same row-major walk.
  - At the end of a sweep, the iteration counter increments.
  - After iteration iter_count-1 completes, go to DONE.
  - While stall is high, run_PE_array shows the idle code and counters hold.
- DONE: done = 1 for one cycle, then IDLE. busy is 0 in DONE.
- abort (any state other than IDLE) overrides everything. Next cycle: IDLE, counters cleared, idle codes on both buses, cfg_ready = 0, no done pulse.
- Simultaneous abort and start in IDLE: abort wins, start is ignored.
- start while busy: ignored.
- Async rst mid-operation: immediate return to reset values; any partial load is discarded.
- No back-pressure from the array beyond stall.

Optional Feature:
- PE_CTRL_PERF_EN defined:
  - Adds output run_cycles [31:0], counting clk cycles spent in RUN, including stalled cycles.
  - Cleared on accepted start, saturates at 32'hFFFF_FFFF, and holds after DONE.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - FSM state encoding.
  - Idle slot code 3'b111.
  - Row/slot field widths and the packing helper {row, slot}.
- Sub-module slot_walker:
  - Row/slot counter with enable, wrap and last-slot flag.
  - Instantiated twice: one for LOAD, one for RUN.

Test Plan:
- Reset mid-LOAD after 5 words -> all outputs reset immediately; next start requires a fresh 16 words.
- start, iter_count = 2, cfg_valid always 1 -> 16 init strobes 00000..11011, with pe_config = word k one cycle after each handshake. Then 32 run strobes, two sweeps 00000..11011, then done for exactly 1 cycle.
- cfg_valid toggling 1/0 during LOAD -> init strobes only after handshakes, idle code 00111 in gaps, still exactly 16 words accepted.
- stall high for 3 cycles mid-RUN at {row 2, slot 1} -> run bus 00111 for 3 cycles, then resumes at 10001 with no slot skipped or repeated.
- iter_count = 0 -> 16 config words accepted, no run strobe, done 1 cycle after the last init strobe.
- abort asserted in RUN iteration 1 -> next cycle IDLE, idle codes, busy = 0, no done; a subsequent start restarts from LOAD.

Source files
------------

// File: rtl/pe_array_sequencer_pkg.sv
// pe_array_sequencer_pkg: shared FSM encoding, select-field widths and idle code for the PE array sequencer.
`ifndef PE_inst
`define PE_inst 32
`endif
package pe_array_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int ROW_W = 2;
  localparam int SLOT_W = 3;
  localparam int SEL_W = ROW_W + SLOT_W;
  localparam int CFG_W_DEF = `PE_inst;
  localparam logic [SLOT_W-1:0] IDLE_SLOT = 3'b111;
  localparam logic [SEL_W-1:0] IDLE_SEL = {2'b00, IDLE_SLOT};
  function automatic logic [SEL_W-1:0] pack_sel(input logic [ROW_W-1:0] row, input logic [SLOT_W-1:0] slot);
    return {row, slot};
  endfunction
endpackage

// File: rtl/pe_array_sequencer_if.sv
// pe_array_sequencer_if: config handshake and PE array init/run/config buses.
interface pe_array_sequencer_if #(parameter int CFG_W = pe_array_sequencer_pkg::CFG_W_DEF);
  import pe_array_sequencer_pkg::*;
  logic cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic cfg_ready;
  logic [SEL_W-1:0] init_PE_array;
  logic [SEL_W-1:0] run_PE_array;
  logic [CFG_W-1:0] pe_config;
  modport master (input cfg_valid, cfg_data, output cfg_ready, init_PE_array, run_PE_array, pe_config);
  modport slave (output cfg_valid, cfg_data, input cfg_ready, init_PE_array, run_PE_array, pe_config);
endinterface

// File: rtl/pe_array_sequencer_slot_walker.sv
// pe_array_sequencer_slot_walker: row-major row/slot counter with enable, clear and last-slot flag.
module pe_array_sequencer_slot_walker
  import pe_array_sequencer_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int SLOTS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [ROW_W-1:0] row,
  output logic [SLOT_W-1:0] slot,
  output logic last
);
  logic row_end, slot_end;
  assign slot_end = slot == SLOT_W'(SLOTS - 1);
  assign row_end = row == ROW_W'(ROWS - 1);
  assign last = row_end && slot_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= '0;
      slot <= '0;
    end else if (clr) begin
      row <= '0;
      slot <= '0;
    end else if (en) begin
      slot <= slot_end ? '0 : slot + 1'b1;
      row <= slot_end ? (row_end ? '0 : row + 1'b1) : row;
    end
endmodule

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: loads ROWS*SLOTS config words then sweeps run strobes; PE_CTRL_PERF_EN adds run_cycles.
module pe_array_sequencer
  import pe_array_sequencer_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int SLOTS = 4,
  parameter int CFG_W = CFG_W_DEF,
  parameter int ITER_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic [ITER_W-1:0] iter_count,
  input  logic stall,
  output logic busy,
  output logic done,
`ifdef PE_CTRL_PERF_EN
  output logic [31:0] run_cycles,
`endif
  pe_array_sequencer_if.master bus
);
  state_t state;
  logic [ITER_W-1:0] iter_cnt, iter;
  logic accept, run_en, load_last, run_last;
  logic [ROW_W-1:0] load_row, run_row;
  logic [SLOT_W-1:0] load_slot, run_slot;
  assign accept = state == LOAD && bus.cfg_valid && bus.cfg_ready && !abort;
  assign run_en = state == RUN && !stall && !abort;
  pe_array_sequencer_slot_walker #(.ROWS(ROWS), .SLOTS(SLOTS)) u_load (
    .clk(clk), .rst(rst), .clr(abort || state == IDLE), .en(accept),
    .row(load_row), .slot(load_slot), .last(load_last)
  );
  pe_array_sequencer_slot_walker #(.ROWS(ROWS), .SLOTS(SLOTS)) u_run (
    .clk(clk), .rst(rst), .clr(abort || state != RUN), .en(run_en),
    .row(run_row), .slot(run_slot), .last(run_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      iter_cnt <= '0;
      iter <= '0;
      bus.cfg_ready <= 1'b0;
      bus.init_PE_array <= IDLE_SEL;
      bus.run_PE_array <= IDLE_SEL;
      bus.pe_config <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      iter <= '0;
      bus.cfg_ready <= 1'b0;
      bus.init_PE_array <= IDLE_SEL;
      bus.run_PE_array <= IDLE_SEL;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      bus.init_PE_array <= accept ? pack_sel(load_row, load_slot) : IDLE_SEL;
      bus.run_PE_array <= run_en ? pack_sel(run_row, run_slot) : IDLE_SEL;
      if (accept) bus.pe_config <= bus.cfg_data;
      done <= state == DONE;
      unique case (state)
        IDLE: if (start) begin
          state <= LOAD;
          iter_cnt <= iter_count;
          iter <= '0;
          bus.cfg_ready <= !stall;
          busy <= 1'b1;
        end
        LOAD: begin
          bus.cfg_ready <= !stall && !(accept && load_last);
          if (accept && load_last) begin
            state <= iter_cnt == '0 ? DONE : RUN;
            busy <= iter_cnt != '0;
          end
        end
        RUN: if (run_en && run_last) begin
          if (iter + 1'b1 == iter_cnt) begin
            state <= DONE;
            busy <= 1'b0;
          end else iter <= iter + 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
`ifdef PE_CTRL_PERF_EN
  // counts every RUN cycle, stalled or not, and holds after completion
  always_ff @(posedge clk or posedge rst)
    if (rst) run_cycles <= '0;
    else if (state == IDLE && start && !abort) run_cycles <= '0;
    else if (state == RUN && run_cycles != '1) run_cycles <= run_cycles + 1'b1;
`endif
endmodule
